// File: rtl/date_counter_if.sv
// date_counter_if: groups the date counter's control, load and date/strobe
// signals so the counter and its driver connect through one bundle.
// The master side issues ticks and loads; the slave side (the counter)
// presents the registered date, the error flag and the rollover strobes.
interface date_counter_if #(
    parameter int unsigned YEAR_W = 12
);
    logic              tick;
    logic              load;
    logic [4:0]        ld_day;
    logic [3:0]        ld_month;
    logic [YEAR_W-1:0] ld_year;
    logic [4:0]        day;
    logic [3:0]        month;
    logic [YEAR_W-1:0] year;
    logic              err;
    logic              month_end;
    logic              year_end;

    modport master (
        output tick, load, ld_day, ld_month, ld_year,
        input  day, month, year, err, month_end, year_end
    );

    modport slave (
        input  tick, load, ld_day, ld_month, ld_year,
        output day, month, year, err, month_end, year_end
    );
endinterface

// File: rtl/date_counter.sv
// date_counter: registered calendar date (day/month/year) advanced by a
// one-cycle tick, with synchronous loading of an arbitrary date, a sticky
// invalid-load flag and one-cycle month/year rollover strobes.
//
// Optional feature: define LEAP_YEAR_EN to give February 29 days in
// Gregorian leap years. Without it February always has 28 days and no
// leap logic exists. MONTH30 = 1 (every month 30 days) overrides it.
module date_counter #(
    parameter int unsigned YEAR_W     = 12,
    parameter int unsigned RESET_YEAR = 2000,
    parameter int unsigned MONTH30    = 0
) (
    input  logic          clk,
    input  logic          rst_n,
    date_counter_if.slave bus
);

    // Registered state and its next-state values
    logic [4:0]        day_q,      day_d;
    logic [3:0]        month_q,    month_d;
    logic [YEAR_W-1:0] year_q,     year_d;
    logic              err_q,      err_d;
    logic              monthEnd_q, monthEnd_d;
    logic              yearEnd_q,  yearEnd_d;

    // Leap flags for the current year and for the year being loaded
    logic curLeap;
    logic ldLeap;

    // Month lengths for the current month and the month being loaded
    logic [4:0] curLen;
    logic [4:0] ldLen;

    // Load validation result
    logic ldValid;

    // Length of month m; leap only matters for February in calendar mode.
    // Out-of-range months return 0 so nothing can ever validate against them.
    function automatic logic [4:0] monthLen(input logic [3:0] m, input logic leap);
        logic [4:0] len;
        len = 5'd0;
        if (m >= 4'd1 && m <= 4'd12) begin
            if (MONTH30 != 0) begin
                len = 5'd30;
            end else begin
                case (m)
                    4'd4, 4'd6, 4'd9, 4'd11: len = 5'd30;
                    4'd2:                    len = leap ? 5'd29 : 5'd28;
                    default:                 len = 5'd31;
                endcase
            end
        end
        return len;
    endfunction

`ifdef LEAP_YEAR_EN
    // Gregorian rule on the unsigned year: divisible by 4, and not a
    // century unless divisible by 400.
    function automatic logic isLeap(input logic [YEAR_W-1:0] y);
        int unsigned yy;
        logic        div4;
        logic        div100;
        logic        div400;
        yy     = 32'(y);
        div4   = (yy % 32'd4)   == 32'd0;
        div100 = (yy % 32'd100) == 32'd0;
        div400 = (yy % 32'd400) == 32'd0;
        return div4 && (!div100 || div400);
    endfunction

    // Leap status of the live year and the candidate load year
    always_comb begin
        curLeap = isLeap(year_q);
        ldLeap  = isLeap(bus.ld_year);
    end
`else
    // Leap years are not modelled: February is always 28 days
    always_comb begin
        curLeap = 1'b0;
        ldLeap  = 1'b0;
    end
`endif

    // Month lengths and validity of the date presented on the load inputs
    always_comb begin
        curLen  = monthLen(month_q, curLeap);
        ldLen   = monthLen(bus.ld_month, ldLeap);
        ldValid = (bus.ld_month >= 4'd1) && (bus.ld_month <= 4'd12) &&
                  (bus.ld_day != 5'd0) && (bus.ld_day <= ldLen);
    end

    // Next-state: load beats tick; a tick is ignored while the error flag
    // is set, and the strobes default low so they last a single cycle.
    always_comb begin
        day_d      = day_q;
        month_d    = month_q;
        year_d     = year_q;
        err_d      = err_q;
        monthEnd_d = 1'b0;
        yearEnd_d  = 1'b0;
        if (bus.load) begin
            if (ldValid) begin
                day_d   = bus.ld_day;
                month_d = bus.ld_month;
                year_d  = bus.ld_year;
                err_d   = 1'b0;
            end else begin
                err_d   = 1'b1;
            end
        end else if (bus.tick && !err_q) begin
            if (day_q < curLen) begin
                day_d = day_q + 5'd1;
            end else begin
                day_d      = 5'd1;
                monthEnd_d = 1'b1;
                if (month_q == 4'd12) begin
                    month_d   = 4'd1;
                    year_d    = year_q + {{(YEAR_W-1){1'b0}}, 1'b1};
                    yearEnd_d = 1'b1;
                end else begin
                    month_d = month_q + 4'd1;
                end
            end
        end
    end

    // State registers with synchronous active-low reset to 1 January RESET_YEAR
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            day_q      <= 5'd1;
            month_q    <= 4'd1;
            year_q     <= YEAR_W'(RESET_YEAR);
            err_q      <= 1'b0;
            monthEnd_q <= 1'b0;
            yearEnd_q  <= 1'b0;
        end else begin
            day_q      <= day_d;
            month_q    <= month_d;
            year_q     <= year_d;
            err_q      <= err_d;
            monthEnd_q <= monthEnd_d;
            yearEnd_q  <= yearEnd_d;
        end
    end

    assign bus.day       = day_q;
    assign bus.month     = month_q;
    assign bus.year      = year_q;
    assign bus.err       = err_q;
    assign bus.month_end = monthEnd_q;
    assign bus.year_end  = yearEnd_q;

endmodule

// File: tb/tb_date_counter.sv
// tb_date_counter: scoreboard bench for date_counter. Two instances share
// clock and reset: dutA uses real month lengths, dutL the 30-day legacy mode.
// The driver pushes the hand-computed expected state for each issued cycle;
// the monitor pops one entry after every clock edge and compares.
module tb_date_counter;

    localparam int unsigned YW = 12;

    typedef struct {
        bit              sel;
        logic [4:0]      d;
        logic [3:0]      m;
        logic [YW-1:0]   y;
        logic            e;
        logic            me;
        logic            ye;
        string           name;
    } exp_t;

    logic clk;
    logic rst_n;

    date_counter_if #(.YEAR_W(YW)) busA();
    date_counter_if #(.YEAR_W(YW)) busL();

    date_counter #(.YEAR_W(YW), .RESET_YEAR(2000), .MONTH30(0)) dutA (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (busA.slave)
    );

    date_counter #(.YEAR_W(YW), .RESET_YEAR(2000), .MONTH30(1)) dutL (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (busL.slave)
    );

    exp_t expQ[$];
    exp_t monEntry;
    int   testsRun    = 0;
    int   testsFailed = 0;
    bit   countEn     = 0;
    int   meCount     = 0;

    // Free-running clock, period 10
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Compare one scoreboard entry against the selected instance
    task automatic checkOutput(input exp_t e);
        logic [4:0]    aD;
        logic [3:0]    aM;
        logic [YW-1:0] aY;
        logic          aE, aMe, aYe;
        if (e.sel) begin
            aD = busL.day; aM = busL.month; aY = busL.year;
            aE = busL.err; aMe = busL.month_end; aYe = busL.year_end;
        end else begin
            aD = busA.day; aM = busA.month; aY = busA.year;
            aE = busA.err; aMe = busA.month_end; aYe = busA.year_end;
        end
        testsRun++;
        if ({aD, aM, aY, aE, aMe, aYe} !== {e.d, e.m, e.y, e.e, e.me, e.ye}) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %0d/%0d/%0d err=%b me=%b ye=%b, required %0d/%0d/%0d err=%b me=%b ye=%b",
                     e.name, aD, aM, aY, aE, aMe, aYe, e.d, e.m, e.y, e.e, e.me, e.ye);
        end
    endtask

    // Monitor: one entry per issued cycle, sampled 1 time unit after the edge
    always @(posedge clk) begin
        #1;
        if (countEn && busL.month_end) meCount++;
        if (expQ.size() > 0) begin
            monEntry = expQ.pop_front();
            checkOutput(monEntry);
        end
    end

    // Drive one cycle of inputs to the selected instance and queue its result
    task automatic applyStimulus(
        input bit sel, input logic rstN, input logic ld, input logic tk,
        input int ldD, input int ldM, input int ldY,
        input int eD, input int eM, input int eY,
        input logic eE, input logic eMe, input logic eYe, input string nm);
        exp_t e;
        @(negedge clk);
        rst_n = rstN;
        busA.load = 1'b0; busA.tick = 1'b0;
        busL.load = 1'b0; busL.tick = 1'b0;
        if (sel) begin
            busL.load = ld; busL.tick = tk;
            busL.ld_day = 5'(ldD); busL.ld_month = 4'(ldM); busL.ld_year = YW'(ldY);
        end else begin
            busA.load = ld; busA.tick = tk;
            busA.ld_day = 5'(ldD); busA.ld_month = 4'(ldM); busA.ld_year = YW'(ldY);
        end
        e.sel = sel; e.d = 5'(eD); e.m = 4'(eM); e.y = YW'(eY);
        e.e = eE; e.me = eMe; e.ye = eYe; e.name = nm;
        expQ.push_back(e);
    endtask

    initial begin
        int d, m, y;
        logic me, ye;
        rst_n = 1'b0;
        busA.tick = 1'b0; busA.load = 1'b0; busA.ld_day = '0; busA.ld_month = '0; busA.ld_year = '0;
        busL.tick = 1'b0; busL.load = 1'b0; busL.ld_day = '0; busL.ld_month = '0; busL.ld_year = '0;

        // Reset with tick held high, then first tick
        applyStimulus(0, 0, 0, 1, 0, 0, 0,    1, 1, 2000, 0, 0, 0, "reset1");
        applyStimulus(0, 0, 0, 1, 0, 0, 0,    1, 1, 2000, 0, 0, 0, "reset2");
        applyStimulus(1, 0, 0, 1, 0, 0, 0,    1, 1, 2000, 0, 0, 0, "reset_legacy");
        applyStimulus(0, 1, 0, 1, 0, 0, 0,    2, 1, 2000, 0, 0, 0, "first_tick");

        // Year rollover and year wrap
        applyStimulus(0, 1, 1, 0, 31, 12, 1999, 31, 12, 1999, 0, 0, 0, "ld_31_12_1999");
        applyStimulus(0, 1, 0, 1, 0, 0, 0,     1, 1, 2000, 0, 1, 1, "year_roll");
        applyStimulus(0, 1, 0, 0, 0, 0, 0,     1, 1, 2000, 0, 0, 0, "strobe_clear");
        applyStimulus(0, 1, 1, 0, 31, 12, 4095, 31, 12, 4095, 0, 0, 0, "ld_31_12_4095");
        applyStimulus(0, 1, 0, 1, 0, 0, 0,     1, 1, 0, 0, 1, 1, "year_wrap");

        // 31-day and 30-day month ends
        applyStimulus(0, 1, 1, 0, 30, 1, 2023, 30, 1, 2023, 0, 0, 0, "ld_30_1");
        applyStimulus(0, 1, 0, 1, 0, 0, 0,    31, 1, 2023, 0, 0, 0, "jan31");
        applyStimulus(0, 1, 0, 1, 0, 0, 0,     1, 2, 2023, 0, 1, 0, "feb1");
        applyStimulus(0, 1, 1, 0, 30, 11, 2023, 30, 11, 2023, 0, 0, 0, "ld_30_11");
        applyStimulus(0, 1, 0, 1, 0, 0, 0,     1, 12, 2023, 0, 1, 0, "dec1");

        // February
`ifdef LEAP_YEAR_EN
        applyStimulus(0, 1, 1, 0, 28, 2, 2024, 28, 2, 2024, 0, 0, 0, "ld_28_2_2024");
        applyStimulus(0, 1, 0, 1, 0, 0, 0,    29, 2, 2024, 0, 0, 0, "feb29_2024");
        applyStimulus(0, 1, 0, 1, 0, 0, 0,     1, 3, 2024, 0, 1, 0, "mar1_2024");
        applyStimulus(0, 1, 1, 0, 28, 2, 1900, 28, 2, 1900, 0, 0, 0, "ld_28_2_1900");
        applyStimulus(0, 1, 0, 1, 0, 0, 0,     1, 3, 1900, 0, 1, 0, "mar1_1900");
        applyStimulus(0, 1, 1, 0, 29, 2, 2000, 29, 2, 2000, 0, 0, 0, "ld_29_2_2000");
        applyStimulus(0, 1, 1, 0, 29, 2, 2023, 29, 2, 2000, 1, 0, 0, "ld_29_2_2023_bad");
`else
        applyStimulus(0, 1, 1, 0, 28, 2, 2024, 28, 2, 2024, 0, 0, 0, "ld_28_2_2024");
        applyStimulus(0, 1, 0, 1, 0, 0, 0,     1, 3, 2024, 0, 1, 0, "mar1_2024");
        applyStimulus(0, 1, 1, 0, 29, 2, 2024, 1, 3, 2024, 1, 0, 0, "ld_29_2_2024_bad");
        applyStimulus(0, 1, 1, 0, 29, 2, 2000, 1, 3, 2024, 1, 0, 0, "ld_29_2_2000_bad");
`endif

        // Invalid loads, sticky error, recovery
        applyStimulus(0, 1, 1, 0, 15, 3, 2023, 15, 3, 2023, 0, 0, 0, "ld_15_3");
        applyStimulus(0, 1, 1, 0, 31, 4, 2023, 15, 3, 2023, 1, 0, 0, "ld_31_4_bad");
        applyStimulus(0, 1, 0, 1, 0, 0, 0,    15, 3, 2023, 1, 0, 0, "tick_ignored1");
        applyStimulus(0, 1, 0, 1, 0, 0, 0,    15, 3, 2023, 1, 0, 0, "tick_ignored2");
        applyStimulus(0, 1, 1, 0, 0, 5, 2023, 15, 3, 2023, 1, 0, 0, "ld_day0_bad");
        applyStimulus(0, 1, 1, 0, 10, 13, 2023, 15, 3, 2023, 1, 0, 0, "ld_month13_bad");
        applyStimulus(0, 1, 1, 0, 5, 0, 2023,  15, 3, 2023, 1, 0, 0, "ld_month0_bad");
        applyStimulus(0, 1, 1, 0, 30, 4, 2023, 30, 4, 2023, 0, 0, 0, "ld_30_4_recover");
        applyStimulus(0, 1, 0, 1, 0, 0, 0,     1, 5, 2023, 0, 1, 0, "may1");

        // Load and tick together: load wins, tick dropped
        applyStimulus(0, 1, 1, 1, 10, 6, 2023, 10, 6, 2023, 0, 0, 0, "ld_tick_prio");
        applyStimulus(0, 1, 0, 0, 0, 0, 0,    10, 6, 2023, 0, 0, 0, "prio_hold");

        // Legacy 30-day mode
        applyStimulus(1, 1, 1, 0, 30, 1, 2023, 30, 1, 2023, 0, 0, 0, "leg_ld_30_1");
        applyStimulus(1, 1, 0, 1, 0, 0, 0,     1, 2, 2023, 0, 1, 0, "leg_feb1");
        applyStimulus(1, 1, 1, 0, 31, 3, 2023, 1, 2, 2023, 1, 0, 0, "leg_ld_31_bad");
        applyStimulus(1, 1, 0, 1, 0, 0, 0,     1, 2, 2023, 1, 0, 0, "leg_tick_ignored");
        applyStimulus(1, 1, 1, 0, 29, 2, 2023, 29, 2, 2023, 0, 0, 0, "leg_ld_29_2");
        applyStimulus(1, 1, 0, 1, 0, 0, 0,    30, 2, 2023, 0, 0, 0, "leg_feb30");
        applyStimulus(1, 1, 0, 1, 0, 0, 0,     1, 3, 2023, 0, 1, 0, "leg_mar1");
        applyStimulus(1, 1, 1, 0, 1, 1, 2023,  1, 1, 2023, 0, 0, 0, "leg_ld_1_1");

        // 360 back-to-back ticks through a legacy year
        d = 1; m = 1; y = 2023;
        countEn = 1'b1;
        for (int i = 0; i < 360; i++) begin
            me = 1'b0; ye = 1'b0;
            if (d == 30) begin
                d = 1; me = 1'b1;
                if (m == 12) begin m = 1; y = y + 1; ye = 1'b1; end
                else m = m + 1;
            end else begin
                d = d + 1;
            end
            applyStimulus(1, 1, 0, 1, 0, 0, 0, d, m, y, 0, me, ye, "leg_sweep");
        end
        applyStimulus(1, 1, 0, 0, 0, 0, 0, 1, 1, 2024, 0, 0, 0, "leg_sweep_end");
        countEn = 1'b0;
        testsRun++;
        if (meCount != 12) begin
            testsFailed++;
            $display("[TB] FAIL leg_month_end_count: got %0d, required 12", meCount);
        end

        // Let the monitor drain, bounded
        for (int i = 0; i < 10 && expQ.size() != 0; i++) @(negedge clk);
        if (expQ.size() != 0) begin
            testsRun++;
            testsFailed++;
            $display("[TB] FAIL scoreboard_drain: got %0d pending, required 0", expQ.size());
        end

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule

// File: doc/date_counter.md
# date_counter

Registered calendar date counter that advances day/month/year on a single-cycle `tick`, with synchronous load of an arbitrary date and validity checking. It is the sequential, parametrised successor of the team's combinational today/tomorrow logic. That logic handled a fixed 30-day month. This block adds real month lengths, year rollover, optional leap years and end-of-period strobes. It sits behind the system tick generator and feeds timestamping logic.

## Interface
- `YEAR_W`, 12, year field width in bits; range 0 to 2^YEAR_W−1.
- `RESET_YEAR`, 2000, year value loaded at reset; must fit in `YEAR_W`.
- `MONTH30`, 0, 1 = every month has 30 days (legacy mode); 0 = real calendar lengths.
- `clk` in 1 — single clock, rising edge.
- `rst_n` in 1 — synchronous, active-low reset.
- `tick` in 1 — advance date by one day; single-cycle pulse.
- `load` in 1 — load `ld_day`/`ld_month`/`ld_year`.
- `ld_day` in 5 — day to load, 1..31.
- `ld_month` in 4 — month to load, 1..12.
- `ld_year` in `YEAR_W` — year to load.
- `day` out 5 — current day.
- `month` out 4 — current month.
- `year` out `YEAR_W` — current year.
- `err` out 1 — sticky invalid-load flag.
- `month_end` out 1 — one-cycle strobe on month rollover.
- `year_end` out 1 — one-cycle strobe on year rollover.

## Operation
- **Reset.** `rst_n`=0 at a rising edge sets `day`=1, `month`=1, `year`=`RESET_YEAR`, `err`=0, `month_end`=0, `year_end`=0. Reset overrides `load` and `tick`.
- **Month length `L`.**
  - `MONTH30`=1: L=30 for all months.
  - Otherwise: L=31 for months 1,3,5,7,8,10,12; L=30 for months 4,6,9,11; L=28 for month 2, or 29 if leap (see Configuration).
- **Priority per edge.** reset > `load` > `tick`.
- **Load.**
  - The loaded date is valid iff 1≤`ld_month`≤12 and 1≤`ld_day`≤L(`ld_month`,`ld_year`).
  - Valid load: registers take the loaded values and `err` is cleared.
  - Invalid load: date registers hold their values and `err` is set.
  - A load never asserts `month_end` or `year_end`.
  - A `tick` in the same cycle as `load` is dropped.
- **Tick** (only when `err`=0; ignored when `err`=1):
  - `day`<L: `day`+1.
  - `day`=L and `month`<12: `day`=1, `month`+1, `month_end`=1.
  - `day`=L and `month`=12: `day`=1, `month`=1, `year`+1, `month_end`=1, `year_end`=1.
  - `year`=2^YEAR_W−1 wraps to 0; no extra flag.
- **`err`** is sticky. It clears only on a valid load or on reset.
- **Strobes** are high for exactly the one cycle after the causing edge and are 0 otherwise.

## Timing
- All outputs are registered. A tick or load sampled at edge N is visible after edge N; latency is 1 cycle.
- Back-to-back ticks on consecutive cycles each advance one day. No bubble is required.
- `tick` held high for k cycles produces k advances.
- `load` while `err`=1 is evaluated normally, so a valid load recovers in 1 cycle.
- Strobes coincide with the cycle in which the new `day`=1 is visible.

## Configuration
- `LEAP_YEAR_EN` defined (and `MONTH30`=0):
  - February has 29 days in leap years, 28 otherwise.
  - A year is leap iff divisible by 4 and (not divisible by 100 or divisible by 400), computed on the unsigned `year` value.
  - Load validation uses the same rule on `ld_year`.
- `LEAP_YEAR_EN` not defined: February always has 28 days and no leap logic is synthesised.
- `MONTH30`=1 takes precedence and the macro has no effect.

## Test plan
- **Reset.** Assert `rst_n`=0 for 2 cycles with `tick`=1 → 1/1/2000, `err`=0, strobes 0. Release and pulse `tick` once → 2/1/2000.
- **Year rollover and wrap.**
  - Load 31/12/1999, then `tick` → 1/1/2000 with `month_end`=`year_end`=1 for one cycle.
  - With `YEAR_W`=12, load 31/12/4095, then `tick` → year 0.
- **February.**
  - With `LEAP_YEAR_EN`: load 28/2/2024, then 2 ticks → 29/2 then 1/3; load 28/2/1900, then `tick` → 1/3; load 29/2/2000 → accepted.
  - Without the macro: load 29/2/2024 → `err`=1 and date unchanged.
- **Invalid load.**
  - Load 31/4/2023 → `err`=1, date held, subsequent ticks ignored.
  - Load 0/5/2023 and load month 13 → `err`=1.
  - Valid load 30/4/2023 → `err`=0; next `tick` → 1/5 with `month_end`=1.
- **Priority.** `load` and `tick` in the same cycle with load 10/6/2023 → 10/6/2023, not 11/6.
- **Legacy mode.** With `MONTH30`=1, load 30/1/2023 then `tick` → 1/2; load 31/x → `err`=1; sweep all ticks through 360 days → `year`+1 with exactly 12 `month_end` strobes.
